// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB RX packet sequencer.
// Packet result codes, PID nibbles, the expected SYNC byte, the CRC16
// constants and the sequencer state encoding all live here.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      PKT_NONE  = 3'd0,
      PKT_OUT   = 3'd1,
      PKT_IN    = 3'd2,
      PKT_DATA0 = 3'd3,
      PKT_DATA1 = 3'd4,
      PKT_ACK   = 3'd5,
      PKT_NAK   = 3'd6,
      PKT_ERROR = 3'd7
   } rx_packet_t;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;

   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PID,
      ST_TOKEN,
      ST_DATA,
      ST_HS_EOP,
      ST_DONE,
      ST_ERR,
      ST_WAIT_IDLE
   } state_t;

   // Maps a PID low nibble to the result code reported on completion.
   function automatic rx_packet_t pid_decode(input logic [3:0] pid);
      case (pid)
         PID_OUT:   return PKT_OUT;
         PID_IN:    return PKT_IN;
         PID_DATA0: return PKT_DATA0;
         PID_DATA1: return PKT_DATA1;
         PID_ACK:   return PKT_ACK;
         PID_NAK:   return PKT_NAK;
         default:   return PKT_ERROR;
      endcase
   endfunction

endpackage

// File: rtl/usb_rx_pkt_ctrl_if.sv
// Bundle between the RX front-end and the packet sequencer.
// Strobe semantics (no back-pressure anywhere): rx_byte is meaningful only
// in a cycle where byte_complete=1, rx_packet_data only in a cycle where
// store_rx_packet_data=1; d_edge and bit_err are single-cycle events, eop
// is a level. The consumer must accept every strobe in the cycle it occurs.
// dbg_state exposes the sequencer state for checkers.
interface usb_rx_pkt_ctrl_if;
   import usb_rx_pkg::*;

   logic       d_edge;
   logic       byte_complete;
   logic [7:0] rx_byte;
   logic       eop;
   logic       bit_err;
   logic       enable_timer;
   logic [2:0] rx_packet;
   logic [7:0] rx_packet_data;
   logic       store_rx_packet_data;
   logic       rx_busy;
   state_t     dbg_state;

   modport master (
      output d_edge, byte_complete, rx_byte, eop, bit_err,
      input  enable_timer, rx_packet, rx_packet_data, store_rx_packet_data,
             rx_busy, dbg_state
   );

   modport slave (
      input  d_edge, byte_complete, rx_byte, eop, bit_err,
      output enable_timer, rx_packet, rx_packet_data, store_rx_packet_data,
             rx_busy, dbg_state
   );

endinterface

// File: rtl/usb_rx_pkt_ctrl_crc16.sv
// Byte-wide USB CRC16 register (poly 0x8005, LSB of each byte first).
// crc_next is the combinational result of folding 'data' into the current
// register, so the caller can test the residual in the same cycle as the
// final byte.
module rx_crc16
   import usb_rx_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] crc,
   output logic [15:0] crc_next
);

   logic [15:0] c;
   logic        fb;

   // Fold one byte into the register, bit 0 first.
   always_comb begin
      c  = crc;
      fb = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
      crc_next = c;
   end

   // CRC state register with clear taking priority over update.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)   crc <= CRC16_INIT;
      else if (clr) crc <= CRC16_INIT;
      else if (en)  crc <= crc_next;
   end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// USB RX packet sequencer: walks SYNC -> PID -> body -> EOP, classifies
// the packet on rx_packet and streams DATA payload with the two trailing
// CRC bytes held back in a 2-entry pipe and never emitted.
// Optional build macro RX_CRC16_EN adds a CRC16 residual check on DATA
// packets; without it the CRC bytes are simply stripped.
module usb_rx_pkt_ctrl
   import usb_rx_pkg::*;
#(
   parameter int         MAX_PAYLOAD = 64,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
)(
   input  logic            clk,
   input  logic            n_rst,
   usb_rx_pkt_ctrl_if.slave bus
);

   localparam logic [7:0] BODY_LIMIT = 8'(MAX_PAYLOAD + 2);

   state_t     state, state_next;
   logic [6:0] body_cnt;
   logic       cnt_ovf;
   logic [7:0] body_wide, cnt_after;
   logic       over;
   logic [7:0] pipe0, pipe1;
   rx_packet_t pkt_code, code_new;
   logic       cnt_inc, data_push, emit, code_load;
   logic       crc_ok;

   logic       enable_timer_q, store_q, rx_busy_q;
   logic [7:0] data_q;
   rx_packet_t rx_packet_q;

   assign body_wide = {1'b0, body_cnt} + 8'd1;
   assign over      = cnt_ovf | body_wide[7] | (body_wide > BODY_LIMIT);
   // Count after this cycle's byte, so a byte arriving with eop is seen first.
   assign cnt_after = bus.byte_complete ? body_wide : {1'b0, body_cnt};

`ifdef RX_CRC16_EN
   logic [15:0] crc_q, crc_next;
   logic        crc_clr;

   assign crc_clr = (state == ST_IDLE);

   rx_crc16 u_crc16 (
      .clk      (clk),
      .n_rst    (n_rst),
      .clr      (crc_clr),
      .en       (data_push),
      .data     (bus.rx_byte),
      .crc      (crc_q),
      .crc_next (crc_next)
   );

   assign crc_ok = ((bus.byte_complete ? crc_next : crc_q) == CRC16_RESIDUAL);
`else
   assign crc_ok = 1'b1;
`endif

   // Next-state and per-cycle action decode; bit_err > byte_complete > eop.
   always_comb begin
      state_next = state;
      cnt_inc    = 1'b0;
      data_push  = 1'b0;
      emit       = 1'b0;
      code_load  = 1'b0;
      code_new   = pkt_code;
      case (state)
         ST_IDLE: begin
            if (bus.d_edge) state_next = ST_SYNC;
         end
         ST_SYNC: begin
            if (bus.bit_err) state_next = ST_ERR;
            else begin
               if (bus.byte_complete)
                  state_next = (bus.rx_byte == SYNC_BYTE) ? ST_PID : ST_ERR;
               if (bus.eop) state_next = ST_ERR;
            end
         end
         ST_PID: begin
            if (bus.bit_err) state_next = ST_ERR;
            else begin
               if (bus.byte_complete) begin
                  code_load = 1'b1;
                  code_new  = pid_decode(bus.rx_byte[3:0]);
                  if (bus.rx_byte[7:4] != ~bus.rx_byte[3:0]) state_next = ST_ERR;
                  else begin
                     case (bus.rx_byte[3:0])
                        PID_OUT, PID_IN:     state_next = ST_TOKEN;
                        PID_DATA0, PID_DATA1: state_next = ST_DATA;
                        PID_ACK, PID_NAK:    state_next = ST_HS_EOP;
                        default:             state_next = ST_ERR;
                     endcase
                  end
               end
               if (bus.eop) state_next = ST_ERR;
            end
         end
         ST_TOKEN: begin
            if (bus.bit_err) state_next = ST_ERR;
            else begin
               if (bus.byte_complete) begin
                  cnt_inc = 1'b1;
                  if (body_cnt >= 7'd2) state_next = ST_ERR;
               end
               if (bus.eop && state_next != ST_ERR)
                  state_next = (cnt_after == 8'd2) ? ST_DONE : ST_ERR;
            end
         end
         ST_DATA: begin
            if (bus.bit_err) state_next = ST_ERR;
            else begin
               if (bus.byte_complete) begin
                  if (over) state_next = ST_ERR;
                  else begin
                     cnt_inc   = 1'b1;
                     data_push = 1'b1;
                     emit      = (body_cnt >= 7'd2);
                  end
               end
               if (bus.eop && state_next != ST_ERR) begin
                  if (cnt_after < 8'd2) state_next = ST_ERR;
                  else begin
                     state_next = ST_DONE;
                     code_load  = 1'b1;
                     code_new   = crc_ok ? pkt_code : PKT_ERROR;
                  end
               end
            end
         end
         ST_HS_EOP: begin
            if (bus.bit_err || bus.byte_complete) state_next = ST_ERR;
            else if (bus.eop) state_next = ST_DONE;
         end
         ST_DONE: begin
            if (!bus.eop) state_next = ST_IDLE;
         end
         ST_ERR: begin
            if (bus.eop) state_next = ST_WAIT_IDLE;
         end
         ST_WAIT_IDLE: begin
            if (!bus.eop) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Body counter, 2-entry payload pipe and latched packet code.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         body_cnt <= '0;
         cnt_ovf  <= 1'b0;
         pipe0    <= '0;
         pipe1    <= '0;
         pkt_code <= PKT_NONE;
      end else begin
         if (state == ST_IDLE) begin
            body_cnt <= '0;
            cnt_ovf  <= 1'b0;
         end else if (cnt_inc) begin
            body_cnt <= body_wide[6:0];
            cnt_ovf  <= cnt_ovf | body_wide[7];
         end
         if (data_push) begin
            if (body_cnt == 7'd0)      pipe0 <= bus.rx_byte;
            else if (body_cnt == 7'd1) pipe1 <= bus.rx_byte;
            else begin
               pipe0 <= pipe1;
               pipe1 <= bus.rx_byte;
            end
         end
         if (code_load) pkt_code <= code_new;
      end
   end

   // Registered outputs; rx_packet is only rewritten from DONE or ERR.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         enable_timer_q <= 1'b0;
         rx_busy_q      <= 1'b0;
         store_q        <= 1'b0;
         data_q         <= 8'h00;
         rx_packet_q    <= PKT_NONE;
      end else begin
         enable_timer_q <= state_next inside {ST_SYNC, ST_PID, ST_TOKEN, ST_DATA, ST_HS_EOP};
         rx_busy_q      <= (state_next != ST_IDLE);
         store_q        <= emit;
         if (emit) data_q <= pipe0;
         if (state == ST_DONE)     rx_packet_q <= pkt_code;
         else if (state == ST_ERR) rx_packet_q <= PKT_ERROR;
      end
   end

   assign bus.enable_timer         = enable_timer_q;
   assign bus.rx_busy              = rx_busy_q;
   assign bus.store_rx_packet_data = store_q;
   assign bus.rx_packet_data       = data_q;
   assign bus.rx_packet            = rx_packet_q;
   assign bus.dbg_state            = state;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Bench for usb_rx_pkt_ctrl: directed packets plus randomized packets,
// scored against a packet-level model of the classification and payload
// rules. Honours RX_CRC16_EN when it is defined for the build.
module tb_usb_rx_pkt_ctrl;
   import usb_rx_pkg::*;

   localparam int MAX_PAYLOAD = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   usb_rx_pkt_ctrl_if bus ();

   usb_rx_pkt_ctrl #(.MAX_PAYLOAD(MAX_PAYLOAD), .SYNC_BYTE(8'h80)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] body_q[$];
   logic [7:0] mon_exp;
   logic [7:0] pid_tab[10];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // ---------------- reference model ----------------
`ifdef RX_CRC16_EN
   function automatic bit crc_good();
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (body_q[k])
         for (int b = 0; b < 8; b++) begin
            fb = c[15] ^ body_q[k][b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      return c == 16'h800D;
   endfunction
`endif

   function automatic logic [2:0] model_code(input logic [7:0] sync_b, input logic [7:0] pid_b,
                                             input int berr_idx);
      int n;
      n = body_q.size();
      if (sync_b != 8'h80) return 3'd7;
      if (pid_b[7:4] != ~pid_b[3:0]) return 3'd7;
      if (berr_idx >= 0 && berr_idx < n) return 3'd7;
      case (pid_b[3:0])
         4'h1: return (n == 2) ? 3'd1 : 3'd7;
         4'h9: return (n == 2) ? 3'd2 : 3'd7;
         4'h3, 4'hB: begin
            if (n < 2 || n > MAX_PAYLOAD + 2) return 3'd7;
`ifdef RX_CRC16_EN
            if (!crc_good()) return 3'd7;
`endif
            return (pid_b[3:0] == 4'h3) ? 3'd3 : 3'd4;
         end
         4'h2: return (n == 0) ? 3'd5 : 3'd7;
         4'hA: return (n == 0) ? 3'd6 : 3'd7;
         default: return 3'd7;
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   // Every store pulse must carry the oldest outstanding expected payload byte.
   always @(negedge clk) begin
      if (n_rst === 1'b1 && bus.store_rx_packet_data === 1'b1) begin
         if (exp_q.size() == 0) check("stray_store", 16'd1, 16'd0);
         else begin
            mon_exp = exp_q.pop_front();
            check("store_data", {8'h00, bus.rx_packet_data}, {8'h00, mon_exp});
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b, input bit exp_store, input bit with_eop,
                            input string tag, input int gap_max);
      bus.rx_byte       = b;
      bus.byte_complete = 1'b1;
      if (with_eop) bus.eop = 1'b1;
      tick();
      bus.byte_complete = 1'b0;
      check({tag, "_store_timing"}, {15'd0, bus.store_rx_packet_data}, {15'd0, exp_store});
      repeat ($urandom_range(0, gap_max)) tick();
   endtask

   task automatic run_pkt(input string name, input logic [7:0] sync_b, input logic [7:0] pid_b,
                          input int berr_idx, input bit eop_last, input int gap_max);
      int n, limit, waited;
      bit is_data;
      logic [2:0] exp_code;
      n        = body_q.size();
      exp_code = model_code(sync_b, pid_b, berr_idx);
      is_data  = (sync_b == 8'h80) && (pid_b[7:4] == ~pid_b[3:0]) &&
                 (pid_b[3:0] == 4'h3 || pid_b[3:0] == 4'hB);
      limit = (n < MAX_PAYLOAD + 2) ? n : MAX_PAYLOAD + 2;
      if (berr_idx >= 0 && berr_idx < limit) limit = berr_idx;
      if (is_data) for (int i = 2; i < limit; i++) exp_q.push_back(body_q[i-2]);

      bus.d_edge = 1'b1;
      tick();
      bus.d_edge = 1'b0;
      check({name, "_busy_start"}, {15'd0, bus.rx_busy}, 16'd1);
      check({name, "_timer_start"}, {15'd0, bus.enable_timer}, 16'd1);
      send_byte(sync_b, 1'b0, 1'b0, name, gap_max);
      send_byte(pid_b, 1'b0, 1'b0, name, gap_max);
      for (int i = 0; i < n; i++) begin
         if (i == berr_idx) begin
            bus.bit_err = 1'b1;
            tick();
            bus.bit_err = 1'b0;
         end
         send_byte(body_q[i], is_data && i >= 2 && i < limit, eop_last && (i == n - 1),
                   name, gap_max);
      end
      bus.eop = 1'b1;
      tick();
      tick();
      check({name, "_code_in_eop"}, {13'd0, bus.rx_packet}, {13'd0, exp_code});
      check({name, "_busy_in_eop"}, {15'd0, bus.rx_busy}, 16'd1);
      bus.eop = 1'b0;
      waited  = 0;
      while (bus.rx_busy === 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check({name, "_idle"}, {15'd0, bus.rx_busy}, 16'd0);
      check({name, "_timer_off"}, {15'd0, bus.enable_timer}, 16'd0);
      check({name, "_code"}, {13'd0, bus.rx_packet}, {13'd0, exp_code});
      check({name, "_stores_drained"}, 16'(exp_q.size()), 16'd0);
      exp_q.delete();
      tick();
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_timer"}, {15'd0, bus.enable_timer}, 16'd0);
      check({name, "_code"},  {13'd0, bus.rx_packet}, 16'd0);
      check({name, "_data"},  {8'h00, bus.rx_packet_data}, 16'd0);
      check({name, "_store"}, {15'd0, bus.store_rx_packet_data}, 16'd0);
      check({name, "_busy"},  {15'd0, bus.rx_busy}, 16'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [7:0] sync_r, pid_r;
      int n_r, berr_r;
      bit last_r;

      pid_tab = '{8'hE1, 8'h69, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'hD3, 8'h1E, 8'hC3, 8'h4B};
      n_rst = 1'b0;
      bus.d_edge = 1'b0; bus.byte_complete = 1'b0; bus.rx_byte = 8'h00;
      bus.eop = 1'b0; bus.bit_err = 1'b0;
      repeat (3) tick();
      check_reset_values("in_reset");
      n_rst = 1'b1;
      tick();
      check_reset_values("after_reset");

      body_q = '{8'h12, 8'h34};
      run_pkt("out_token", 8'h80, 8'hE1, -1, 1'b0, 2);
      body_q = '{8'hA5, 8'h3C, 8'h00, 8'h00};
      run_pkt("data0", 8'h80, 8'hC3, -1, 1'b0, 0);
      body_q = '{8'h00, 8'h00};
      run_pkt("data1_zero", 8'h80, 8'h4B, -1, 1'b0, 1);
      body_q = {};
      run_pkt("ack", 8'h80, 8'hD2, -1, 1'b0, 1);
      run_pkt("bad_pid", 8'h80, 8'hD3, -1, 1'b0, 1);
      run_pkt("bad_sync", 8'h00, 8'hE1, -1, 1'b0, 1);
      body_q = '{8'h55};
      run_pkt("nak_with_body", 8'h80, 8'h5A, -1, 1'b0, 0);
      run_pkt("data_short", 8'h80, 8'hC3, -1, 1'b1, 0);
      body_q = '{8'h01, 8'h02, 8'h03};
      run_pkt("token_3_bytes", 8'h80, 8'h69, -1, 1'b0, 0);
      body_q = '{8'h9A, 8'hBC};
      run_pkt("in_eop_with_byte", 8'h80, 8'h69, -1, 1'b1, 1);

      body_q = {};
      for (int i = 0; i < MAX_PAYLOAD + 2; i++) body_q.push_back(8'($urandom_range(0, 255)));
      run_pkt("data_max", 8'h80, 8'h4B, -1, 1'b0, 0);
      body_q.push_back(8'h77);
      run_pkt("data_overflow", 8'h80, 8'hC3, -1, 1'b0, 0);

      body_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
      run_pkt("data_bit_err", 8'h80, 8'hC3, 3, 1'b0, 1);

      // Reset in the middle of a DATA packet, one byte already stored.
      exp_q.push_back(8'h11);
      bus.d_edge = 1'b1;
      tick();
      bus.d_edge = 1'b0;
      send_byte(8'h80, 1'b0, 1'b0, "rst_pkt", 0);
      send_byte(8'hC3, 1'b0, 1'b0, "rst_pkt", 0);
      send_byte(8'h11, 1'b0, 1'b0, "rst_pkt", 0);
      send_byte(8'h22, 1'b0, 1'b0, "rst_pkt", 0);
      send_byte(8'h33, 1'b1, 1'b0, "rst_pkt", 0);
      bus.rx_byte = 8'h44;
      bus.byte_complete = 1'b1;
      #2 n_rst = 1'b0;
      #1 check_reset_values("mid_pkt_reset");
      tick();
      bus.byte_complete = 1'b0;
      tick();
      check_reset_values("held_reset");
      n_rst = 1'b1;
      tick();
      tick();
      check_reset_values("post_reset");
      check("rst_queue", 16'(exp_q.size()), 16'd0);
      exp_q.delete();
      body_q = '{8'hDE, 8'hAD};
      run_pkt("after_reset_token", 8'h80, 8'hE1, -1, 1'b0, 1);

      for (int r = 0; r < 30; r++) begin
         sync_r = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'h80;
         pid_r  = pid_tab[$urandom_range(0, 9)];
         n_r    = $urandom_range(0, 6);
         berr_r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n_r) : -1;
         last_r = (n_r > 0) && ($urandom_range(0, 1) == 1);
         body_q = {};
         for (int i = 0; i < n_r; i++) body_q.push_back(8'($urandom_range(0, 255)));
         run_pkt($sformatf("rand%0d", r), sync_r, pid_r, berr_r, last_r, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
